bitstream_accumulator: RTL and testbench

BITSTREAM_ACCUMULATOR -- requirements
Module: bitstream_accumulator

---
 rtl/sc_pkg.sv | 14 +
 rtl/bitstream_accumulator.sv | 89 ++++++++
 tb/tb_bitstream_accumulator.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing pipeline: accumulator FSM
// states and the common bitstream window length.
package sc_pkg;

  // Window length shared by the exp-constant generator and the accumulator.
  localparam int SC_WINDOW_LENGTH = 1092;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/bitstream_accumulator.sv
// Counts the ones in a fixed-length stochastic bitstream window and presents
// the count with a valid/ready handshake. The start edge samples bit 0; the
// edge sampling the last bit lands the result, so the result is valid
// WINDOW_LENGTH-1 edges after start. A ready+start edge in HOLD chains the
// next window with no idle bubble.
module bitstream_accumulator
  import sc_pkg::*;
#(
  parameter int WINDOW_LENGTH = SC_WINDOW_LENGTH,
  parameter int COUNT_WIDTH   = $clog2(WINDOW_LENGTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   x,
  input  logic                   start,
  input  logic                   ready,
  output logic                   busy,
  output logic                   valid,
  output logic [COUNT_WIDTH-1:0] count_out
);

  // A one-bit window still needs a one-bit index register to stay legal.
  localparam int IDX_W   = (WINDOW_LENGTH > 1) ? $clog2(WINDOW_LENGTH) : 1;
  localparam bit ONE_BIT = (WINDOW_LENGTH == 1);

  state_t                 state, state_next;
  logic [COUNT_WIDTH-1:0] acc;
  logic [IDX_W-1:0]       idx;
  logic                   launch;
  logic                   last;

  // idx holds the index of the bit sampled on the coming edge.
  assign last  = (state == ACCUM) && (idx == IDX_W'(WINDOW_LENGTH - 1));
  assign busy  = (state == ACCUM);
  assign valid = (state == HOLD);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state; launch marks an edge that samples bit 0 of a new window.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = ONE_BIT ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (last) state_next = HOLD;
      end
      HOLD: begin
        if (ready) begin
          if (start) begin
            launch     = 1'b1;
            state_next = ONE_BIT ? HOLD : ACCUM;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, window index and result register. acc never exceeds
  // WINDOW_LENGTH, which COUNT_WIDTH is sized to hold, so no wrap occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      idx       <= '0;
      count_out <= '0;
    end else if (launch) begin
      acc <= COUNT_WIDTH'(x);
      idx <= IDX_W'(1);
      if (ONE_BIT) count_out <= COUNT_WIDTH'(x);
    end else if (state == ACCUM) begin
      acc <= acc + COUNT_WIDTH'(x);
      idx <= idx + IDX_W'(1);
      if (last) count_out <= acc + COUNT_WIDTH'(x);
    end
  end

endmodule

// File: tb/tb_bitstream_accumulator.sv
// Bench for bitstream_accumulator: four instances (WINDOW_LENGTH 8, 4, 1 and
// default) share one stimulus stream; each section checks one instance.
module tb_bitstream_accumulator;

  logic clk = 1'b0;
  logic rst, x, start, ready;

  logic busy8, valid8; logic [3:0]  cnt8;
  logic busy4, valid4; logic [2:0]  cnt4;
  logic busy1, valid1; logic [0:0]  cnt1;
  logic busyd, validd; logic [10:0] cntd;

  always #5 clk = ~clk;

  bitstream_accumulator #(.WINDOW_LENGTH(8)) u8 (
    .clk(clk), .rst(rst), .x(x), .start(start), .ready(ready),
    .busy(busy8), .valid(valid8), .count_out(cnt8));
  bitstream_accumulator #(.WINDOW_LENGTH(4)) u4 (
    .clk(clk), .rst(rst), .x(x), .start(start), .ready(ready),
    .busy(busy4), .valid(valid4), .count_out(cnt4));
  bitstream_accumulator #(.WINDOW_LENGTH(1)) u1 (
    .clk(clk), .rst(rst), .x(x), .start(start), .ready(ready),
    .busy(busy1), .valid(valid1), .count_out(cnt1));
  bitstream_accumulator ud (
    .clk(clk), .rst(rst), .x(x), .start(start), .ready(ready),
    .busy(busyd), .valid(validd), .count_out(cntd));

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];

  typedef struct {
    logic [7:0] pat;         // window bits, bit 0 first
    logic       hold_start;  // keep start high through ACCUM and HOLD
    int         exp;
  } vec_t;

  vec_t vecs[5];
  logic [1091:0] gen;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic dut_valid(input int sel);
    case (sel)
      8: return valid8;
      4: return valid4;
      1: return valid1;
      default: return validd;
    endcase
  endfunction

  function automatic logic dut_busy(input int sel);
    case (sel)
      8: return busy8;
      4: return busy4;
      1: return busy1;
      default: return busyd;
    endcase
  endfunction

  function automatic int dut_count(input int sel);
    case (sel)
      8: return int'(cnt8);
      4: return int'(cnt4);
      1: return int'(cnt1);
      default: return int'(cntd);
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b1; ready = 1'b1; x = 1'b1;
    step(); step();
    rst = 1'b0; start = 1'b0; ready = 1'b0; x = 1'b0;
  endtask

  // Start a window on the selected instance, feed L bits and wait (bounded)
  // for valid; checks latency, busy duration and the scoreboarded count.
  task automatic run_window(input int sel, input int L, input logic [1091:0] p,
                            input logic hold_start, input int exp, input string nm);
    int k, lat, bcnt, e;
    logic done;
    sb.push_back(exp);
    start = 1'b1; x = p[0];
    step();
    if (!hold_start) start = 1'b0;
    lat = 0; k = 1; bcnt = 0;
    done = dut_valid(sel);
    while (!done && lat < L + 16) begin
      if (dut_busy(sel)) bcnt++;
      x = (k < L) ? p[k] : 1'b0;
      k++;
      step();
      lat++;
      done = dut_valid(sel);
    end
    check({nm, " valid"}, int'(done), 1);
    check({nm, " latency"}, lat, L - 1);
    check({nm, " busy_cycles"}, bcnt, L - 1);
    e = sb.pop_front();
    check({nm, " count"}, dut_count(sel), e);
  endtask

  task automatic release_hold();
    start = 1'b0; ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  initial begin
    int e, edges;
    logic saw;
    logic [7:0] alt;

    vecs[0] = '{8'hFF, 1'b0, 8};
    vecs[1] = '{8'h00, 1'b0, 0};
    vecs[2] = '{8'h55, 1'b0, 4};
    vecs[3] = '{8'h81, 1'b1, 2};
    vecs[4] = '{8'h3C, 1'b0, 4};

    // 1092-bit stream with exactly 20 ones, first bit a one.
    for (int i = 0; i < 1092; i++) gen[i] = ((i * 20) % 1092) < 20;

    rst = 1'b0; x = 1'b0; start = 1'b0; ready = 1'b0;

    // Reset overrides start/ready held high.
    do_reset();
    check("rst valid8", int'(valid8), 0);
    check("rst busy8", int'(busy8), 0);
    check("rst cnt8", int'(cnt8), 0);
    check("rst valid1", int'(valid1), 0);
    check("rst cnt1", int'(cnt1), 0);
    check("rst busyd", int'(busyd), 0);
    check("rst cntd", int'(cntd), 0);

    // Table-driven windows on the 8-bit instance, each held 5 cycles.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      run_window(8, 8, {1084'b0, vecs[v].pat}, vecs[v].hold_start, vecs[v].exp,
                 $sformatf("vec%0d", v));
      saw = 1'b1;
      for (int c = 0; c < 5; c++) begin
        start = vecs[v].hold_start;
        step();
        if (!valid8 || int'(cnt8) != vecs[v].exp) saw = 1'b0;
      end
      check($sformatf("vec%0d hold_stable", v), int'(saw), 1);
      release_hold();
      check($sformatf("vec%0d idle_valid", v), int'(valid8), 0);
      check($sformatf("vec%0d idle_busy", v), int'(busy8), 0);
      check($sformatf("vec%0d idle_cnt", v), int'(cnt8), vecs[v].exp);
    end

    // Reset at window bit 4 discards the partial window.
    do_reset();
    alt = 8'b0101_0101;  // sequence 1,0,1,0,... bit 0 first
    start = 1'b1; x = alt[0];
    step();
    start = 1'b0;
    for (int k = 1; k < 4; k++) begin x = alt[k]; step(); end
    rst = 1'b1; x = alt[4];
    step();
    rst = 1'b0;
    check("midrst busy", int'(busy8), 0);
    check("midrst valid", int'(valid8), 0);
    saw = 1'b0;
    for (int c = 0; c < 12; c++) begin x = 1'b1; step(); saw |= valid8; end
    check("midrst no_valid", int'(saw), 0);
    run_window(8, 8, 1092'hFF, 1'b0, 8, "restart");
    release_hold();

    // Back-to-back windows on the 4-bit instance.
    do_reset();
    run_window(4, 4, 1092'hF, 1'b0, 4, "w4a");
    sb.push_back(0);
    ready = 1'b1; start = 1'b1; x = 1'b0;
    step();
    ready = 1'b0; start = 1'b0;
    check("w4b no_bubble busy", int'(busy4), 1);
    check("w4b no_bubble valid", int'(valid4), 0);
    edges = 0;
    while (!valid4 && edges < 20) begin x = 1'b0; step(); edges++; end
    check("w4b latency", edges, 3);
    e = sb.pop_front();
    check("w4b count", int'(cnt4), e);
    release_hold();

    // One-bit window goes straight to HOLD.
    do_reset();
    run_window(1, 1, 1092'h1, 1'b0, 1, "w1a");
    sb.push_back(0);
    ready = 1'b1; start = 1'b1; x = 1'b0;
    step();
    check("w1b valid", int'(valid1), 1);
    e = sb.pop_front();
    check("w1b count", int'(cnt1), e);
    start = 1'b0;
    step();
    ready = 1'b0;
    check("w1 idle valid", int'(valid1), 0);
    check("w1 idle cnt", int'(cnt1), 0);

    // Default-length window over the 20-ones generator stream.
    do_reset();
    run_window(0, 1092, gen, 1'b0, 20, "exp4");
    release_hold();
    check("exp4 idle", int'(validd), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
